// File: rtl/apb_pkg.sv
// Shared types and constants for the round-robin APB master.
package apb_pkg;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Protection attribute driven on every transfer.
  localparam logic PPROT_DEFAULT = 1'b0;

  // Number of byte strobes for a given data width.
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_rr_master_if.sv
// APB bus bundle between the master and the shared slave.
interface apb_rr_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);

  localparam int STRB_WIDTH = strb_width(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pprot;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Stateless round-robin arbiter: first valid request at or after the
// pointer wins, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   grant_idx_o,
  output logic               any_req_o
);

  logic found_s;

  // Scan requesters starting at the pointer and pick the first valid one.
  always_comb begin
    int idx;
    found_s     = 1'b0;
    grant_idx_o = '0;
    grant_o     = '0;
    any_req_o   = |req_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!found_s && req_i[idx]) begin
        found_s     = 1'b1;
        grant_idx_o = PTR_W'(idx);
      end else begin
        found_s     = found_s;
      end
    end
    if (en_i && found_s) begin
      grant_o[grant_idx_o] = 1'b1;
    end else begin
      grant_o = '0;
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ single-command requesters
// onto one APB slave, one transfer in flight, with an ACCESS timeout.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int TIMEOUT    = 15
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0]                  req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_strb_i,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0]               rsp_rdata_o,
  output logic                                rsp_err_o,
  output logic                                rsp_timeout_o,
  apb_rr_master_if.master                     apb
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int STRB_W = strb_width(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      gidx_q, gidx_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic                  arb_en_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic [PTR_W-1:0]      grant_idx_s;
  logic                  any_req_s;
  logic                  accept_s;
  logic [TMR_W-1:0]      timer_inc_s;
  logic                  timeout_hit_s;
  logic [PTR_W-1:0]      ptr_next_s;

  // Grants are only offered while idle and out of reset.
  assign arb_en_s = (state_q == ST_IDLE) && !reset;
  assign accept_s = arb_en_s && any_req_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .en_i        (arb_en_s),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s),
    .any_req_o   (any_req_s)
  );

  assign timer_inc_s   = timer_q + TMR_W'(1);
  assign timeout_hit_s = (timer_inc_s == TMR_W'(TIMEOUT));
  assign ptr_next_s    = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: IDLE -> SETUP -> ACCESS (until ready/timeout) -> RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_SETUP;
        else          state_d = ST_IDLE;
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (apb.pready)         state_d = ST_RESP;
        else if (timeout_hit_s) state_d = ST_RESP;
        else                    state_d = ST_ACCESS;
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next values; bus controls follow the next state
  // so they are registered yet line up with the state they belong to.
  always_comb begin
    ptr_d         = ptr_q;
    gidx_d        = gidx_q;
    timer_d       = timer_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pwrite_d      = pwrite_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_valid_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    psel_d        = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d     = (state_d == ST_ACCESS);
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          gidx_d   = grant_idx_s;
          timer_d  = '0;
          paddr_d  = req_addr_i[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
          pwdata_d = req_wdata_i[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
          pwrite_d = req_write_i[grant_idx_s];
          if (req_write_i[grant_idx_s]) begin
            pstrb_d = req_strb_i[int'(grant_idx_s)*STRB_W +: STRB_W];
          end else begin
            pstrb_d = '0;
          end
        end else begin
          gidx_d = gidx_q;
        end
      end
      ST_SETUP: begin
        timer_d = '0;
      end
      ST_ACCESS: begin
        if (apb.pready) begin
          if (!pwrite_q) begin
            rsp_rdata_d = apb.prdata;
          end else begin
            rsp_rdata_d = rsp_rdata_q;
          end
          rsp_err_d           = apb.pslverr;
          rsp_valid_d[gidx_q] = 1'b1;
        end else if (timeout_hit_s) begin
          timer_d             = timer_inc_s;
          rsp_err_d           = 1'b1;
          rsp_timeout_d       = 1'b1;
          rsp_valid_d[gidx_q] = 1'b1;
        end else begin
          timer_d = timer_inc_s;
        end
      end
      ST_RESP: begin
        ptr_d   = ptr_next_s;
        timer_d = '0;
      end
      default: begin
        timer_d = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q         <= '0;
      gidx_q        <= '0;
      timer_q       <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      gidx_q        <= gidx_d;
      timer_q       <= timer_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready_o   = grant_s;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

  assign apb.paddr   = paddr_q;
  assign apb.pprot   = PPROT_DEFAULT;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master with a small APB SRAM slave model.
module tb_apb_rr_master;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [21:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Slave behaviour knobs.
  int wait_cfg = 0;
  bit err_cfg  = 1'b0;
  bit hang     = 1'b0;
  int wait_cnt = 0;
  logic [31:0] mem [16];

  apb_rr_master_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus ();

  apb_rr_master #(
    .NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(11), .TIMEOUT(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_write_i   (req_write),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_strb_i    (req_strb),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .rsp_timeout_o (rsp_timeout),
    .apb           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: ready after wait_cfg ACCESS cycles unless hung.
  assign bus.pready  = bus.psel && bus.penable && !hang && (wait_cnt >= wait_cfg);
  assign bus.pslverr = bus.pready && err_cfg;
  assign bus.prdata  = mem[bus.paddr[5:2]];

  always @(posedge clk) begin
    if (bus.psel && bus.penable) begin
      if (bus.pready) begin
        wait_cnt <= 0;
        if (bus.pwrite && !err_cfg) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.pstrb[b]) mem[bus.paddr[5:2]][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
          end
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  // One command from requester r; reports accept vector, latency from
  // accept to rsp_valid, response fields and ACCESS-phase observations.
  task automatic xfer(input int r, input logic w, input logic [10:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] acc_vec, output int lat,
                      output logic [1:0] rv, output logic [31:0] rd,
                      output logic e, output logic to, output int acc,
                      output logic [3:0] ps_seen, output logic stable,
                      output logic [3:0] phase);
    int k;
    logic [10:0] a0;
    logic [31:0] d0;
    @(negedge clk);
    req_valid[r]          = 1'b1;
    req_write[r]          = w;
    req_addr[r*11 +: 11]  = a;
    req_wdata[r*32 +: 32] = d;
    req_strb[r*4 +: 4]    = s;
    #1;
    k = 0;
    while (!req_ready[r] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      n_cmp++; n_err++;
      $error("FAIL accept_wait: observed no req_ready expected req_ready[%0d]", r);
    end
    acc_vec = req_ready;
    lat = 0; rv = 2'b00; rd = 32'h0; e = 1'b0; to = 1'b0; acc = 0;
    ps_seen = 4'h0; stable = 1'b1; phase = 4'h0; a0 = 11'h0; d0 = 32'h0;
    while (rv == 2'b00 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid[r] = 1'b0;
        phase[3:2] = {bus.psel, bus.penable};
      end
      if (lat == 2) phase[1:0] = {bus.psel, bus.penable};
      if (bus.psel && bus.penable) begin
        if (acc == 0) begin
          a0 = bus.paddr; d0 = bus.pwdata; ps_seen = bus.pstrb;
        end else if (bus.paddr !== a0 || bus.pwdata !== d0) begin
          stable = 1'b0;
        end
        acc++;
      end
      if (rsp_valid != 2'b00) begin
        rv = rsp_valid; rd = rsp_rdata; e = rsp_err; to = rsp_timeout;
      end
    end
    if (rv == 2'b00) begin
      n_cmp++; n_err++;
      $error("FAIL rsp_wait: observed no rsp_valid expected rsp_valid[%0d]", r);
    end
  endtask

  initial begin
    logic [1:0]  av, rv;
    logic [31:0] rd;
    logic        e, to, st;
    logic [3:0]  ps, ph;
    int          lat, acc;
    logic [1:0]  acc_o [6];
    int          acc_t [6];
    logic [1:0]  rsp_o [6];
    logic [31:0] rsp_d [6];
    int          acc_n, rsp_n, k;
    bit          drop_pend, seen;

    reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_strb = '0;
    repeat (3) @(negedge clk);
    chk("rst_psel", bus.psel, 1'b0);
    chk("rst_penable", bus.penable, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_err", {rsp_err, rsp_timeout}, 2'b00);
    chk("rst_paddr", bus.paddr, 11'h000);
    chk("rst_pwdata", bus.pwdata, 32'h0);
    chk("rst_pprot", bus.pprot, 1'b0);
    reset = 1'b0;

    // Single write then read back.
    xfer(0, 1'b1, 11'h010, 32'hDEADBEEF, 4'hF, av, lat, rv, rd, e, to, acc, ps, st, ph);
    chk("wr_accept", av, 2'b01);
    chk("wr_phase", ph, 4'b1011);
    chk("wr_latency", lat, 3);
    chk("wr_rsp", {rv, e, to}, 4'b0100);
    chk("wr_pstrb", ps, 4'hF);
    xfer(0, 1'b0, 11'h010, 32'h0, 4'hF, av, lat, rv, rd, e, to, acc, ps, st, ph);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    chk("rd_rsp", {rv, e, to}, 4'b0100);

    // Byte strobes.
    xfer(1, 1'b1, 11'h020, 32'h11223344, 4'hF, av, lat, rv, rd, e, to, acc, ps, st, ph);
    chk("strb_full_rsp", rv, 2'b10);
    xfer(1, 1'b1, 11'h020, 32'h0000AA00, 4'h2, av, lat, rv, rd, e, to, acc, ps, st, ph);
    chk("strb_part_pstrb", ps, 4'h2);
    xfer(0, 1'b0, 11'h020, 32'h0, 4'hF, av, lat, rv, rd, e, to, acc, ps, st, ph);
    chk("strb_read_pstrb", ps, 4'h0);
    chk("strb_rdata", rd, 32'h1122AA44);

    // Contention from reset: both requesters continuously valid.
    do_reset(2);
    req_write = 2'b00;
    req_addr  = {11'h020, 11'h010};
    req_valid = 2'b11;
    #1;
    acc_n = 0; rsp_n = 0; drop_pend = 1'b0;
    for (int c = 0; c < 80 && rsp_n < 6; c++) begin
      if (req_ready != 2'b00 && acc_n < 6) begin
        acc_o[acc_n] = req_ready; acc_t[acc_n] = c; acc_n++;
      end
      if (rsp_valid != 2'b00 && rsp_n < 6) begin
        rsp_o[rsp_n] = rsp_valid; rsp_d[rsp_n] = rsp_rdata; rsp_n++;
      end
      if (drop_pend) req_valid = 2'b00;
      if (acc_n == 6) drop_pend = 1'b1;
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("cont_acc_count", acc_n, 6);
    chk("cont_rsp_count", rsp_n, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("cont_grant%0d", i), acc_o[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("cont_rsp%0d", i), rsp_o[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("cont_data%0d", i), rsp_d[i], (i % 2 == 0) ? 32'hDEADBEEF : 32'h1122AA44);
    end
    chk("cont_spacing", acc_t[1] - acc_t[0], 4);

    // Wait states with slave error on the ready cycle.
    wait_cfg = 3; err_cfg = 1'b1;
    xfer(1, 1'b1, 11'h030, 32'h55AA55AA, 4'hF, av, lat, rv, rd, e, to, acc, ps, st, ph);
    chk("wait_latency", lat, 6);
    chk("wait_access_cycles", acc, 4);
    chk("wait_stable", st, 1'b1);
    chk("wait_err", {rv, e, to}, 4'b1010);
    // Slave error on a read still returns the data.
    wait_cfg = 0;
    xfer(0, 1'b0, 11'h010, 32'h0, 4'h0, av, lat, rv, rd, e, to, acc, ps, st, ph);
    chk("slverr_rd", {rv, e, to}, 4'b0110);
    chk("slverr_rdata", rd, 32'hDEADBEEF);
    err_cfg = 1'b0;

    // Timeout with pready held low.
    hang = 1'b1;
    xfer(0, 1'b0, 11'h010, 32'h0, 4'h0, av, lat, rv, rd, e, to, acc, ps, st, ph);
    chk("to_access_cycles", acc, 4);
    chk("to_latency", lat, 6);
    chk("to_rsp", {rv, e, to}, 4'b0111);
    hang = 1'b0;
    xfer(1, 1'b0, 11'h020, 32'h0, 4'h0, av, lat, rv, rd, e, to, acc, ps, st, ph);
    chk("after_to_rsp", {rv, e, to}, 4'b1000);
    chk("after_to_rdata", rd, 32'h1122AA44);

    // Reset during ACCESS: move pointer to 1 first.
    xfer(0, 1'b0, 11'h010, 32'h0, 4'h0, av, lat, rv, rd, e, to, acc, ps, st, ph);
    chk("pre_rst_rsp", rv, 2'b01);
    hang = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[21:11] = 11'h020;
    #1;
    chk("mid_accept", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    k = 0;
    while (!(bus.psel && bus.penable) && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("mid_in_access", {bus.psel, bus.penable}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_bus", {bus.psel, bus.penable}, 2'b00);
    chk("mid_rst_rsp", rsp_valid, 2'b00);
    reset = 1'b0; hang = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    chk("mid_no_rsp", seen, 1'b0);
    req_valid = 2'b11;
    #1;
    chk("post_rst_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    k = 0;
    while (rsp_valid == 2'b00 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("post_rst_rsp", rsp_valid, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound in case a directed step stalls unexpectedly.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1);
  end

endmodule
